// File: rtl/run_pkg.sv
// Shared types and defaults for the run controller and the program top levels.
package run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } run_state_t;

    localparam int CNT_W_DEF = 16;
    localparam int WDOG_DEF  = 60000;

endpackage : run_pkg

// File: rtl/start_edge_det.sv
// Registered edge detector on the host start line.
// During reset the register tracks start, so releasing reset never produces
// a spurious edge: a fall needs a real 1->0 seen after reset is gone.
module start_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic fall,
    output logic rise
);

    logic start_q;

    // Delayed copy of start; reset loads the live value.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= start;
        end else begin
            start_q <= start;
        end
    end

    // Edges relative to the previous sample.
    always_comb begin
        fall = start_q & ~start;
        rise = ~start_q & start;
    end

endmodule : start_edge_det

// File: rtl/run_ctrl.sv
// Responder for the host start/done handshake.
// A falling start launches a run (PC enabled), a halt from Control ends it,
// and a watchdog ends runs that never halt with done plus timeout.
//
// state | meaning
// IDLE  | PC held at 0, waiting for a start fall
// RUN   | PC advancing, counting cycles, watching for halt / watchdog
// DONE  | program halted, done=1 until start rises
// FAULT | watchdog expired, done=1 timeout=1 until start rises
module run_ctrl
    import run_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int WATCHDOG_MAX = WDOG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    output logic             pc_en,
    output logic             pc_init,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WATCHDOG_MAX);

    run_state_t       state_q;
    run_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             start_fall;
    logic             start_rise;

    start_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .fall  (start_fall),
        .rise  (start_rise)
    );

    // Count of the cycle being completed at this edge.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
    end

    // Next state and cycle counter; halt is checked before the watchdog so a
    // halt on the last allowed cycle still reports a clean finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_fall) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (halt) begin
                    state_d = DONE;
                end else if (cnt_inc == WDOG_LIM) begin
                    state_d = FAULT;
                end
            end
            DONE: begin
                if (start_rise) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (start_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the registered state only, so no input reaches them
    // combinationally.
    always_comb begin
        pc_en       = (state_q == RUN);
        pc_init     = (state_q == IDLE);
        done        = (state_q == DONE) || (state_q == FAULT);
        timeout     = (state_q == FAULT);
        cycle_count = cnt_q;
    end

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl with a short watchdog so timeout is reachable.
module tb_run_ctrl;

    localparam int CNT_W = 16;
    localparam int WD    = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             halt;
    logic             pc_en;
    logic             pc_init;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    int n_tests;
    int n_fail;
    bit check_en;
    int pc_en_cnt;

    // Reference model: run progress tracked as flags and an integer count.
    bit m_running;
    bit m_finished;
    bit m_faulted;
    int m_count;
    bit m_prev;

    run_ctrl #(.CNT_W(CNT_W), .WATCHDOG_MAX(WD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .pc_en       (pc_en),
        .pc_init     (pc_init),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        bit fl;
        bit rs;
        if (reset) begin
            m_running  = 1'b0;
            m_finished = 1'b0;
            m_faulted  = 1'b0;
            m_count    = 0;
        end else begin
            fl = m_prev && !start;
            rs = !m_prev && start;
            if (m_running) begin
                m_count = m_count + 1;
                if (halt) begin
                    m_running  = 1'b0;
                    m_finished = 1'b1;
                    m_faulted  = 1'b0;
                end else if (m_count == WD) begin
                    m_running  = 1'b0;
                    m_finished = 1'b1;
                    m_faulted  = 1'b1;
                end
            end else if (m_finished) begin
                if (rs) begin
                    m_finished = 1'b0;
                    m_faulted  = 1'b0;
                end
            end else if (fl) begin
                m_running = 1'b1;
                m_count   = 0;
            end
        end
        m_prev = start;
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("m_pc_en",   int'(pc_en),   int'(m_running));
            cmp("m_pc_init", int'(pc_init), int'(!m_running && !m_finished));
            cmp("m_done",    int'(done),    int'(m_finished));
            cmp("m_timeout", int'(timeout), int'(m_finished && m_faulted));
            cmp("m_count",   int'(cycle_count), m_count);
            if (pc_en) pc_en_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE with start=1: drop start, halt on RUN cycle n.
    // With mid set, start also rises in cycle 1 and falls in cycle 2.
    task automatic run_halt(input int n, input bit mid);
        pc_en_cnt = 0;
        start = 1'b0;
        tick();
        for (int i = 1; i <= n; i++) begin
            cmp("run_pc_en", int'(pc_en), 1);
            cmp("run_no_done", int'(done), 0);
            if (i == n) halt = 1'b1;
            if (mid && i == 1) start = 1'b1;
            if (mid && i == 2) start = 1'b0;
            tick();
        end
        halt = 1'b0;
        cmp("halt_done", int'(done), 1);
        cmp("halt_timeout", int'(timeout), 0);
        cmp("halt_count", int'(cycle_count), n);
        cmp("halt_pc_en", int'(pc_en), 0);
        #4;
        cmp("halt_pc_en_cycles", pc_en_cnt, n);
        if (mid) begin
            start = 1'b0;
            tick();
            cmp("done_hold_fall", int'(done), 1);
        end
        start = 1'b1;
        tick();
        cmp("ack_done_low", int'(done), 0);
        cmp("ack_pc_init", int'(pc_init), 1);
    endtask

    initial begin
        int k;
        n_tests  = 0;
        n_fail   = 0;
        check_en = 1'b0;
        pc_en_cnt = 0;
        m_prev   = 1'b1;
        reset = 1'b1;
        start = 1'b1;
        halt  = 1'b0;

        // Reset with start high.
        tick();
        check_en = 1'b1;
        tick();
        cmp("rst_done", int'(done), 0);
        cmp("rst_pc_en", int'(pc_en), 0);
        cmp("rst_pc_init", int'(pc_init), 1);
        cmp("rst_count", int'(cycle_count), 0);
        cmp("rst_timeout", int'(timeout), 0);

        // Release reset and drop start together; halt on cycle 5.
        pc_en_cnt = 0;
        reset = 1'b0;
        start = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            cmp("r1_pc_en", int'(pc_en), 1);
            if (i == 5) halt = 1'b1;
            tick();
        end
        halt = 1'b0;
        cmp("r1_done", int'(done), 1);
        cmp("r1_timeout", int'(timeout), 0);
        cmp("r1_count", int'(cycle_count), 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("r1_done_hold", int'(done), 1);
        end
        cmp("r1_pc_en_cycles", pc_en_cnt, 5);
        start = 1'b1;
        tick();
        cmp("r1_ack", int'(done), 0);

        // Watchdog: no halt.
        pc_en_cnt = 0;
        start = 1'b0;
        tick();
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        cmp("wd_wait_in_budget", int'(k < 20), 1);
        cmp("wd_done", int'(done), 1);
        cmp("wd_timeout", int'(timeout), 1);
        cmp("wd_count", int'(cycle_count), 8);
        cmp("wd_pc_en", int'(pc_en), 0);
        #4;
        cmp("wd_pc_en_cycles", pc_en_cnt, 8);
        start = 1'b1;
        tick();
        cmp("wd_ack_done", int'(done), 0);
        cmp("wd_ack_timeout", int'(timeout), 0);

        // Halt on the watchdog's last cycle wins.
        run_halt(8, 1'b0);

        // Reset during RUN cycle 3.
        start = 1'b0;
        tick();
        tick();
        tick();
        cmp("rr_pc_en", int'(pc_en), 1);
        reset = 1'b1;
        tick();
        cmp("rr_done", int'(done), 0);
        cmp("rr_count", int'(cycle_count), 0);
        cmp("rr_pc_init", int'(pc_init), 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp("rr_no_run", int'(pc_en), 0);
        end
        start = 1'b1;
        tick();
        cmp("rr_still_idle", int'(pc_en), 0);
        start = 1'b0;
        tick();
        cmp("rr_run_started", int'(pc_en), 1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        cmp("rr_count1", int'(cycle_count), 1);
        start = 1'b1;
        tick();

        // Back-to-back runs; later ones toggle start during RUN.
        for (int n = 1; n <= 5; n++) begin
            run_halt(n, n >= 2);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit in case the flow above stalls.
    initial begin
        #200000;
        $display("FAIL time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

endmodule : tb_run_ctrl

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Responder side of the host start/done handshake for top_level.
- Detects the host's falling edge on start and launches the program by enabling the PC.
- Stops the PC when Control decodes a halt, then raises done and holds it until the host raises start again.
- Also provides a run-cycle counter and a watchdog, so a hung program reports done plus a fault instead of hanging the bench.

Parameters:
- CNT_W, 16, width of cycle_count.
- WATCHDOG_MAX, 16'd60000, number of RUN cycles without halt before FAULT. Must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  host request. A 1->0 transition launches a run; a 0->1 transition acknowledges done.
- halt  input  1  from Control: the instruction currently executing is the halt opcode.
- pc_en  output  1  PC advance enable. High only in RUN.
- pc_init  output  1  forces PC to 0 on the next edge. High in IDLE.
- done  output  1  run finished, normally or by timeout.
- timeout  output  1  watchdog fired. Valid only while done=1.
- cycle_count  output  CNT_W  number of RUN cycles of the last or current run.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset value of every output:
  - state=IDLE
  - done=0, timeout=0, cycle_count=0
  - pc_en=0, pc_init=1
  - start_q is loaded with the current start value, so no edge is detected on the cycle reset is released.
- Edge detect: start_q is a registered copy of start.
  - fall = start_q & ~start
  - rise = ~start_q & start
- States, one transition per rising edge:
  - IDLE: pc_en=0, pc_init=1, done=0. On fall -> RUN, and cycle_count<=0. halt is ignored.
  - RUN: pc_en=1, pc_init=0. Each edge does cycle_count<=cycle_count+1.
    - If halt -> DONE.
    - Else if cycle_count+1 == WATCHDOG_MAX -> FAULT.
    - rise on start is ignored; only reset aborts a run.
  - DONE: done=1, timeout=0, pc_en=0, cycle_count held.
    - On rise -> IDLE; done is low from the next cycle.
    - A fall without a preceding rise is impossible; halt is ignored.
  - FAULT: done=1, timeout=1, pc_en=0, cycle_count=WATCHDOG_MAX. On rise -> IDLE.
- Simultaneous halt and watchdog limit on the same edge: halt wins (DONE, timeout=0).
- Latency:
  - fall sampled at edge k -> state RUN after edge k; first instruction commits at edge k+1.
  - halt high during the Nth RUN cycle -> done=1 after that edge, cycle_count=N.
- done must never be high while a run is in progress or in IDLE. There is no false done after reset.
- Reset mid-RUN, mid-DONE or mid-FAULT: next edge gives IDLE with reset outputs. A fall requires a genuine 1->0 after reset is released.
- start held low through reset release: no run starts until start goes high and then low again.
- Back-to-back runs: DONE -> rise -> IDLE -> fall -> RUN needs a minimum of 2 edges. cycle_count restarts from 0 on every entry to RUN.
- Outputs pc_en, pc_init, done and timeout are combinational decodes of the registered state only, with no input-to-output paths.

Decomposition:
- run_pkg holds:
  - typedef enum logic[1:0] {IDLE, RUN, DONE, FAULT} run_state_t
  - localparam CNT_W_DEF=16
  - localparam WDOG_DEF=60000
- Sub-module start_edge_det: sync-reset register producing fall and rise. It is reused by the other program top levels.
- The counter and FSM stay in run_ctrl.

Test Plan:
- Reset for 2 cycles with start=1 -> done=0, pc_en=0, pc_init=1, cycle_count=0, state IDLE.
- Release reset, drop start at the same edge, pulse halt on the 5th RUN cycle -> pc_en high for exactly 5 cycles, done=1, timeout=0, cycle_count=5. done stays 1 until start=1, then drops 1 cycle later.
- With WATCHDOG_MAX=8 and halt never asserted -> done=1, timeout=1, cycle_count=8, pc_en=0. Raising start returns to IDLE with done=0.
- With WATCHDOG_MAX=8, assert halt on RUN cycle 8 -> done=1, timeout=0, cycle_count=8.
- Assert reset on RUN cycle 3 -> next cycle state IDLE, done=0, cycle_count=0. Holding start low after reset starts no run; start 1 then 0 starts one.
- Five back-to-back runs with halts at cycles 1, 2, 3, 4, 5, using the start rise/fall between runs and start raised in mid-RUN -> each done shows cycle_count equal to the halt cycle, a start rise in RUN has no effect, and no done pulse appears before its halt.
